mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 254 +++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage - data cache request/response, load alignment and ALE detection.
// Optional LL.W/SC.W support (llbit register, llbit_clr input) is compiled in with `define LLSC_EN.
//
// state | meaning
// IDLE  | no access in flight; non-memory ops pass straight through
// REQ   | request presented but not yet accepted by the cache
// WAIT  | load accepted, waiting for the response
// DONE  | result captured, presented to MEM/WB until not held
// DRAIN | flushed load still owes a response; swallow it
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              hold,
`ifdef LLSC_EN
    input  logic              llbit_clr,
`endif
    input  logic              in_valid,
    input  logic [3:0]        in_memop,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_sdata,
    input  logic              in_wen,
    input  logic [4:0]        in_waddr,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              stall_req,
    output logic              dreq_valid,
    input  logic              dreq_ready,
    output logic [3:0]        dreq_wstrb,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [DATA_W-1:0] dreq_wdata,
    input  logic              drsp_valid,
    input  logic [DATA_W-1:0] drsp_rdata,
    output logic              out_valid,
    output logic              out_wen,
    output logic [4:0]        out_waddr,
    output logic [DATA_W-1:0] out_wdata,
    output logic              out_ale,
    output logic [ADDR_W-1:0] out_badv
);

    localparam logic [3:0] OP_LDB  = 4'd1;
    localparam logic [3:0] OP_LDH  = 4'd2;
    localparam logic [3:0] OP_LDW  = 4'd3;
    localparam logic [3:0] OP_LDBU = 4'd4;
    localparam logic [3:0] OP_LDHU = 4'd5;
    localparam logic [3:0] OP_STB  = 4'd6;
    localparam logic [3:0] OP_STH  = 4'd7;
    localparam logic [3:0] OP_STW  = 4'd8;
    localparam logic [3:0] OP_LLW  = 4'd9;
    localparam logic [3:0] OP_SCW  = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t            state;
    logic              res_wen;
    logic [4:0]        res_waddr;
    logic [DATA_W-1:0] res_wdata;
    logic [3:0]        res_op;
    logic [1:0]        res_off;
    logic              res_ll;
    logic              res_sc;
    logic              llbit;
    logic              llbit_clr_i;

    logic is_load, is_store, is_half, is_word, is_ll, is_sc;
    logic is_mem, misalign, sc_fail, mem_ok, req_en;
    logic [3:0]        req_wstrb;
    logic [DATA_W-1:0] req_wdata;

`ifdef LLSC_EN
    assign llbit_clr_i = llbit_clr;
`else
    assign llbit_clr_i = 1'b0;
`endif

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        is_ll    = 1'b0;
        is_sc    = 1'b0;
        case (in_memop)
            OP_LDB, OP_LDBU: is_load = 1'b1;
            OP_LDH, OP_LDHU: begin is_load = 1'b1; is_half = 1'b1; end
            OP_LDW:          begin is_load = 1'b1; is_word = 1'b1; end
            OP_STB:          is_store = 1'b1;
            OP_STH:          begin is_store = 1'b1; is_half = 1'b1; end
            OP_STW:          begin is_store = 1'b1; is_word = 1'b1; end
`ifdef LLSC_EN
            OP_LLW:          begin is_load = 1'b1; is_word = 1'b1; is_ll = 1'b1; end
            OP_SCW:          begin is_store = 1'b1; is_word = 1'b1; is_sc = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign is_mem   = is_load | is_store;
    assign misalign = (is_half & in_addr[0]) | (is_word & (in_addr[1:0] != 2'b00));
    assign sc_fail  = is_sc & ~llbit;
    assign mem_ok   = in_valid & is_mem & ~misalign & ~sc_fail;

    always_comb begin
        req_wstrb = 4'b0000;
        req_wdata = in_sdata;
        if (is_store) begin
            if (is_word) begin
                req_wstrb = 4'b1111;
            end else if (is_half) begin
                req_wstrb = 4'b0011 << in_addr[1:0];
                req_wdata = {2{in_sdata[15:0]}};
            end else begin
                req_wstrb = 4'b0001 << in_addr[1:0];
                req_wdata = {4{in_sdata[7:0]}};
            end
        end
    end

    function automatic logic [DATA_W-1:0] load_ext(input logic [3:0] op, input logic [1:0] off,
                                                   input logic [DATA_W-1:0] rdata);
        logic [DATA_W-1:0] sh;
        sh = rdata >> {off, 3'b000};
        case (op)
            OP_LDB:  load_ext = {{24{sh[7]}}, sh[7:0]};
            OP_LDBU: load_ext = {24'd0, sh[7:0]};
            OP_LDH:  load_ext = {{16{sh[15]}}, sh[15:0]};
            OP_LDHU: load_ext = {16'd0, sh[15:0]};
            default: load_ext = rdata;
        endcase
    endfunction

    always_comb begin
        stall_req  = 1'b0;
        req_en     = 1'b0;
        dreq_valid = 1'b0;
        dreq_wstrb = '0;
        dreq_addr  = '0;
        dreq_wdata = '0;
        out_valid  = 1'b0;
        out_wen    = 1'b0;
        out_waddr  = '0;
        out_wdata  = '0;
        out_ale    = 1'b0;
        out_badv   = '0;
        if (!rst) begin
            case (state)
                S_IDLE, S_DRAIN: begin
                    if (mem_ok) begin
                        stall_req = 1'b1;
                        req_en    = (state == S_IDLE) && !flush;
                    end else begin
                        out_valid = in_valid & ~flush;
                        out_waddr = in_waddr;
                        if (in_valid && is_mem && misalign) begin
                            out_ale  = ~flush;
                            out_badv = in_addr;
                        end else if (in_valid && is_sc) begin
                            out_wen = in_wen;
                        end else begin
                            out_wen   = in_wen;
                            out_wdata = in_wdata;
                        end
                    end
                end
                S_REQ: begin
                    stall_req = 1'b1;
                    req_en    = !flush;
                end
                S_WAIT: stall_req = 1'b1;
                S_DONE: begin
                    if (!flush) begin
                        out_valid = 1'b1;
                        out_wen   = res_wen;
                        out_waddr = res_waddr;
                        out_wdata = res_wdata;
                    end
                end
                default: ;
            endcase
        end
        if (req_en) begin
            dreq_valid = 1'b1;
            dreq_wstrb = req_wstrb;
            dreq_addr  = {in_addr[ADDR_W-1:2], 2'b00};
            dreq_wdata = req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            res_wen   <= 1'b0;
            res_waddr <= '0;
            res_wdata <= '0;
            res_op    <= '0;
            res_off   <= '0;
            res_ll    <= 1'b0;
            res_sc    <= 1'b0;
            llbit     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_REQ: begin
                    if (dreq_valid && dreq_ready) begin
                        res_wen   <= is_load ? in_wen : (is_sc & in_wen);
                        res_waddr <= in_waddr;
                        res_wdata <= {{(DATA_W-1){1'b0}}, is_sc};
                        res_op    <= in_memop;
                        res_off   <= in_addr[1:0];
                        res_ll    <= is_ll;
                        res_sc    <= is_sc;
                        state     <= is_load ? S_WAIT : S_DONE;
                    end else if (dreq_valid) begin
                        state <= S_REQ;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    // a response arriving in the flush cycle settles the debt; no drain needed
                    if (flush) begin
                        state <= drsp_valid ? S_IDLE : S_DRAIN;
                    end else if (drsp_valid) begin
                        res_wdata <= load_ext(res_op, res_off, drsp_rdata);
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (flush || !hold) state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (drsp_valid) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (llbit_clr_i) begin
                llbit <= 1'b0;
            end else if (state == S_DONE && !flush) begin
                if (res_ll)      llbit <= 1'b1;
                else if (res_sc) llbit <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage against a per-instruction reference model.
// Cache handshake delays, hold cycles and flush-in-WAIT are exercised; LL/SC when LLSC_EN is defined.
`timescale 1ns/1ps
module tb_mem_stage;

`ifdef LLSC_EN
    localparam bit LLSC = 1'b1;
`else
    localparam bit LLSC = 1'b0;
`endif

    localparam int K_NONE   = 0;
    localparam int K_ALE    = 1;
    localparam int K_LOAD   = 2;
    localparam int K_STORE  = 3;
    localparam int K_SCFAIL = 4;

    logic        clk = 1'b0;
    logic        rst, flush, hold, llbit_clr;
    logic        in_valid, in_wen;
    logic [3:0]  in_memop;
    logic [31:0] in_addr, in_sdata, in_wdata;
    logic [4:0]  in_waddr;
    logic        stall_req, dreq_valid, dreq_ready, drsp_valid;
    logic [3:0]  dreq_wstrb;
    logic [31:0] dreq_addr, dreq_wdata, drsp_rdata;
    logic        out_valid, out_wen, out_ale;
    logic [4:0]  out_waddr;
    logic [31:0] out_wdata, out_badv;

    int n_checks = 0;
    int n_fail   = 0;
    bit llbit_m  = 1'b0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .hold       (hold),
`ifdef LLSC_EN
        .llbit_clr  (llbit_clr),
`endif
        .in_valid   (in_valid),
        .in_memop   (in_memop),
        .in_addr    (in_addr),
        .in_sdata   (in_sdata),
        .in_wen     (in_wen),
        .in_waddr   (in_waddr),
        .in_wdata   (in_wdata),
        .stall_req  (stall_req),
        .dreq_valid (dreq_valid),
        .dreq_ready (dreq_ready),
        .dreq_wstrb (dreq_wstrb),
        .dreq_addr  (dreq_addr),
        .dreq_wdata (dreq_wdata),
        .drsp_valid (drsp_valid),
        .drsp_rdata (drsp_rdata),
        .out_valid  (out_valid),
        .out_wen    (out_wen),
        .out_waddr  (out_waddr),
        .out_wdata  (out_wdata),
        .out_ale    (out_ale),
        .out_badv   (out_badv)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present one instruction and play the cache; compare against the architectural result.
    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rdata, input logic wen, input logic [4:0] waddr,
                          input logic [31:0] wdata, input int rdy_dly, input int rsp_dly,
                          input int hold_n);
        int size, kind, lat, first_out, dreq_cycles, accepts, rdy_cnt, rsp_cnt, holds;
        logic [31:0] off, v, exp_wdata, exp_wstrb, exp_sdata;
        logic exp_wen;
        bit done, memop, is_ld, issues;

        off = addr % 4;
        memop = (op >= 1 && op <= 8) || (LLSC && (op == 9 || op == 10));
        case (op)
            4'd1, 4'd4, 4'd6: size = 1;
            4'd2, 4'd5, 4'd7: size = 2;
            default:          size = 4;
        endcase
        is_ld = (op >= 1 && op <= 5) || op == 9;
        exp_wstrb = 32'd0;
        exp_sdata = 32'd0;
        exp_wdata = 32'd0;
        if (!memop) begin
            kind = K_NONE; exp_wen = wen; exp_wdata = wdata;
        end else if (addr % size != 0) begin
            kind = K_ALE; exp_wen = 1'b0;
        end else if (op == 10 && !llbit_m) begin
            kind = K_SCFAIL; exp_wen = wen; exp_wdata = 32'd0;
        end else if (is_ld) begin
            kind = K_LOAD; exp_wen = wen;
            if (size == 4) begin
                v = rdata;
            end else if (size == 2) begin
                v = (rdata >> (8 * off)) % 65536;
                if (op == 2 && v >= 32768) v += 32'hFFFF0000;
            end else begin
                v = (rdata >> (8 * off)) % 256;
                if (op == 1 && v >= 128) v += 32'hFFFFFF00;
            end
            exp_wdata = v;
        end else begin
            kind = K_STORE;
            exp_wen   = (op == 10) ? wen : 1'b0;
            exp_wdata = (op == 10) ? 32'd1 : 32'd0;
            if (size == 4) begin
                exp_wstrb = 32'd15; exp_sdata = sdata;
            end else if (size == 2) begin
                exp_wstrb = 32'd3 << off; exp_sdata = (sdata % 65536) * 32'h00010001;
            end else begin
                exp_wstrb = 32'd1 << off; exp_sdata = (sdata % 256) * 32'h01010101;
            end
        end
        issues = (kind == K_LOAD) || (kind == K_STORE);
        lat = (kind == K_LOAD) ? rdy_dly + rsp_dly + 2 : (kind == K_STORE) ? rdy_dly + 1 : 0;

        in_valid = 1'b1; in_memop = op; in_addr = addr; in_sdata = sdata;
        in_wen = wen; in_waddr = waddr; in_wdata = wdata;
        first_out = -1; done = 1'b0; dreq_cycles = 0; accepts = 0;
        rdy_cnt = 0; rsp_cnt = -1; holds = 0;

        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(negedge clk);
            dreq_ready = 1'b0; drsp_valid = 1'b0; hold = 1'b0; drsp_rdata = $urandom;
            if (dreq_valid) begin
                dreq_cycles++;
                check_val("dreq_addr", dreq_addr, addr - off);
                check_val("dreq_wstrb", 32'(dreq_wstrb), exp_wstrb);
                if (kind == K_STORE) check_val("dreq_wdata", dreq_wdata, exp_sdata);
                if (rdy_cnt == rdy_dly) begin
                    dreq_ready = 1'b1;
                    accepts++;
                    if (kind == K_LOAD) rsp_cnt = 0;
                end else begin
                    rdy_cnt++;
                end
            end else if (rsp_cnt >= 0) begin
                if (rsp_cnt == rsp_dly) begin
                    drsp_valid = 1'b1; drsp_rdata = rdata; rsp_cnt = -1;
                end else begin
                    rsp_cnt++;
                end
            end
            if (out_valid) begin
                if (first_out < 0) begin
                    first_out = cyc;
                    check_val("latency", 32'(cyc), 32'(lat));
                end
                check_val("stall_out", 32'(stall_req), 32'd0);
                check_val("out_wen", 32'(out_wen), 32'(exp_wen));
                check_val("out_ale", 32'(out_ale), 32'(kind == K_ALE));
                if (kind == K_ALE) begin
                    check_val("out_badv", out_badv, addr);
                end else begin
                    check_val("out_waddr", 32'(out_waddr), 32'(waddr));
                    check_val("out_wdata", out_wdata, exp_wdata);
                end
                if (holds < hold_n) begin
                    hold = 1'b1; holds++;
                end else begin
                    done = 1'b1;
                end
            end else begin
                check_val("stall_busy", 32'(stall_req), 32'd1);
            end
            @(posedge clk); #1;
        end
        if (!done) check_val("timeout", 32'd0, 32'd1);
        check_val("dreq_cycles", 32'(dreq_cycles), issues ? 32'(rdy_dly + 1) : 32'd0);
        check_val("accepts", 32'(accepts), issues ? 32'd1 : 32'd0);
        if (kind == K_LOAD && op == 9) llbit_m = 1'b1;
        if (kind == K_STORE && op == 10) llbit_m = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle(input bit clr);
        in_valid = 1'b0;
        in_memop = 4'($urandom_range(0, 15));
        llbit_clr = clr;
        @(negedge clk);
        check_val("idle_out_valid", 32'(out_valid), 32'd0);
        check_val("idle_dreq_valid", 32'(dreq_valid), 32'd0);
        check_val("idle_stall", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        llbit_clr = 1'b0;
        if (clr) llbit_m = 1'b0;
    endtask

    task automatic flush_in_wait();
        in_valid = 1'b1; in_memop = 4'd3; in_addr = 32'h0000_5000; in_sdata = 32'd0;
        in_wen = 1'b1; in_waddr = 5'd7; in_wdata = 32'd0;
        @(negedge clk);
        check_val("fl_first_req", 32'(dreq_valid), 32'd1);
        dreq_ready = 1'b1;
        @(posedge clk); #1;
        dreq_ready = 1'b0; flush = 1'b1;
        @(negedge clk);
        check_val("fl_out_valid", 32'(out_valid), 32'd0);
        check_val("fl_dreq_valid", 32'(dreq_valid), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_addr = 32'h0000_6004; in_waddr = 5'd9;
        @(negedge clk);
        check_val("drain_stall", 32'(stall_req), 32'd1);
        check_val("drain_no_req", 32'(dreq_valid), 32'd0);
        check_val("drain_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        drsp_valid = 1'b1; drsp_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        check_val("drain_rsp_no_req", 32'(dreq_valid), 32'd0);
        check_val("drain_rsp_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        drsp_valid = 1'b0;
        run_op(4'd3, 32'h0000_6004, 32'd0, 32'h600D_600D, 1'b1, 5'd9, 32'd0, 0, 1, 0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] addr, mask;
        rst = 1'b1; flush = 1'b0; hold = 1'b0; llbit_clr = 1'b0;
        in_valid = 1'b1; in_memop = 4'd0; in_addr = 32'h0000_0100; in_sdata = 32'h1111_2222;
        in_wen = 1'b1; in_waddr = 5'd3; in_wdata = 32'hA5A5_5A5A;
        dreq_ready = 1'b0; drsp_valid = 1'b0; drsp_rdata = 32'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_wen", 32'(out_wen), 32'd0);
        check_val("rst_out_wdata", out_wdata, 32'd0);
        check_val("rst_stall", 32'(stall_req), 32'd0);
        check_val("rst_dreq_valid", 32'(dreq_valid), 32'd0);
        check_val("rst_out_ale", 32'(out_ale), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;

        run_op(4'd1, 32'h0000_1003, 32'd0, 32'h80AA_BBCC, 1'b1, 5'd4, 32'hFFFF_FFFF, 0, 0, 0);
        run_op(4'd7, 32'h0000_2002, 32'h0000_1234, 32'd0, 1'b1, 5'd5, 32'h0, 3, 0, 0);
        run_op(4'd3, 32'h0000_3001, 32'd0, 32'd0, 1'b1, 5'd6, 32'h0, 0, 0, 0);
        run_op(4'd0, 32'h0000_3001, 32'd0, 32'd0, 1'b1, 5'd8, 32'hCAFE_F00D, 0, 0, 0);
        flush_in_wait();
        run_op(4'd5, 32'h0000_4002, 32'd0, 32'h8765_4321, 1'b1, 5'd10, 32'h0, 0, 0, 2);
        run_op(4'd2, 32'h0000_4002, 32'd0, 32'h8765_4321, 1'b1, 5'd11, 32'h0, 1, 2, 1);

`ifdef LLSC_EN
        run_op(4'd9, 32'h0000_7000, 32'd0, 32'h1234_5678, 1'b1, 5'd12, 32'h0, 0, 0, 0);
        run_op(4'd10, 32'h0000_7000, 32'hAAAA_BBBB, 32'd0, 1'b1, 5'd13, 32'h0, 0, 0, 0);
        run_op(4'd9, 32'h0000_7000, 32'd0, 32'h1234_5678, 1'b1, 5'd12, 32'h0, 0, 0, 0);
        idle_cycle(1'b1);
        run_op(4'd10, 32'h0000_7000, 32'hAAAA_BBBB, 32'd0, 1'b1, 5'd13, 32'h0, 0, 0, 0);
`endif

        for (int i = 0; i < 150; i++) begin
            op   = 4'($urandom_range(0, 15));
            addr = $urandom;
            case (op)
                4'd1, 4'd4, 4'd6: mask = 32'h3;
                4'd2, 4'd5, 4'd7: mask = 32'h2;
                default:          mask = 32'h0;
            endcase
            if ($urandom_range(0, 3) != 0) addr = (addr & ~32'h3) | (32'($urandom_range(0, 3)) & mask);
            run_op(op, addr, $urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            if ($urandom_range(0, 5) == 0) idle_cycle(LLSC && ($urandom_range(0, 1) == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
